// File: rtl/lock_pkg.sv
`default_nettype none
// =============================================================================
// lock_pkg : shared encodings and sizes for the combination-lock datapath
// Revision : 1.0
// =============================================================================
package lock_pkg;

    localparam int CODE_DIGITS = 4;
    localparam int DIGIT_W     = 4;
    localparam int CODE_W      = CODE_DIGITS * DIGIT_W;
    localparam int LEN_W       = $clog2(CODE_DIGITS + 1);
    localparam int ERR_W       = 2;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_INPUT  = 3'd1,
        S_ERROR  = 3'd2,
        S_ALARM  = 3'd3,
        S_UNLOCK = 3'd4,
        S_SETKEY = 3'd5
    } lock_state_e;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
        return (d <= 4'd9);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// =============================================================================
// hold_timer : loadable down-counter; expired while enabled and count is zero
// Revision   : 1.0
// =============================================================================
module hold_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over counting; the count parks at zero rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/lock_seq_ctrl.sv
`default_nettype none
// =============================================================================
// lock_seq_ctrl : combination-lock sequencer (FSM, code entry, key, error count)
// Revision      : 1.0
// =============================================================================
module lock_seq_ctrl
    import lock_pkg::*;
#(
    parameter int                MAX_ERRORS  = 3,
    parameter logic [CODE_W-1:0] DEFAULT_KEY = 16'h1234,
    parameter int                ERR_HOLD    = 50_000_000,
    parameter int                ALARM_HOLD  = 500_000_000,
    parameter int                UNLOCK_HOLD = 250_000_000,
    parameter int                IDLE_TO     = 500_000_000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               digit_valid_i,
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic               btn_ok_i,
    input  logic               btn_back_i,
    input  logic               btn_admin_i,
    output logic [2:0]         state_o,
    output logic [CODE_W-1:0]  code_o,
    output logic [LEN_W-1:0]   code_len_o,
    output logic [ERR_W-1:0]   err_cnt_o,
    output logic               unlocked_o,
    output logic               alarm_on_o,
    output logic               admin_mode_o,
    output logic               key_updated_o
);

    localparam int TMR_W = $clog2(max_int(max_int(ERR_HOLD, ALARM_HOLD),
                                          max_int(UNLOCK_HOLD, IDLE_TO))) + 1;
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(CODE_DIGITS);
    localparam logic [LEN_W-1:0] ONE_LEN  = LEN_W'(1);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(MAX_ERRORS - 1);

    lock_state_e       state_q,   state_d;
    logic [CODE_W-1:0] code_q,    code_d;
    logic [LEN_W-1:0]  len_q,     len_d;
    logic [ERR_W-1:0]  err_q,     err_d;
    logic [CODE_W-1:0] key_q,     key_d;
    logic              key_upd_q, key_upd_d;

    logic              reload;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_value;
    logic              tmr_en;
    logic              tmr_exp;

    logic              ev_ok;
    logic              ev_back;
    logic              ev_digit;
    logic              ev_admin;
    logic              dig_acc;
    logic              back_acc;
    logic [CODE_W-1:0] code_push;
    logic [CODE_W-1:0] code_pop;

    // Only the highest-priority pulse in a cycle survives.
    assign ev_ok    = btn_ok_i;
    assign ev_back  = btn_back_i & ~btn_ok_i;
    assign ev_digit = digit_valid_i & ~btn_ok_i & ~btn_back_i;
    assign ev_admin = btn_admin_i & ~btn_ok_i & ~btn_back_i & ~digit_valid_i;

    assign dig_acc   = ev_digit && is_bcd(digit_i) && (len_q != FULL_LEN);
    assign back_acc  = ev_back && (len_q != '0);
    assign code_push = {code_q[CODE_W-DIGIT_W-1:0], digit_i};
    assign code_pop  = code_q >> DIGIT_W;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        len_d     = len_q;
        err_d     = err_q;
        key_d     = key_q;
        key_upd_d = 1'b0;
        reload    = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;

        unique case (state_q)
            S_WAIT: begin
                if (dig_acc) begin
                    code_d  = code_push;
                    len_d   = len_q + 1'b1;
                    state_d = S_INPUT;
                end
            end

            S_INPUT: begin
                if (ev_ok) begin
                    if ((len_q == FULL_LEN) && (code_q == key_q)) begin
                        err_d   = '0;
                        state_d = S_UNLOCK;
                    end else if (err_q >= ERR_LAST) begin
                        err_d   = ERR_LAST;
                        state_d = S_ALARM;
                    end else begin
                        err_d   = err_q + 1'b1;
                        state_d = S_ERROR;
                    end
                end else if (back_acc) begin
                    code_d = code_pop;
                    len_d  = len_q - 1'b1;
                    reload = 1'b1;
                    if (len_q == ONE_LEN) begin
                        state_d = S_WAIT;
                    end
                end else if (dig_acc) begin
                    code_d = code_push;
                    len_d  = len_q + 1'b1;
                    reload = 1'b1;
                end else if (tmr_exp) begin
                    state_d = S_WAIT;
                end
            end

            S_ERROR: begin
                if (tmr_exp) begin
                    state_d = S_WAIT;
                end
            end

            S_ALARM: begin
                if (tmr_exp) begin
                    err_d   = '0;
                    state_d = S_WAIT;
                end
            end

            S_UNLOCK: begin
                if (ev_ok) begin
                    state_d = S_WAIT;
                end else if (ev_admin) begin
                    state_d = S_SETKEY;
                end else if (tmr_exp) begin
                    state_d = S_WAIT;
                end
            end

            S_SETKEY: begin
                if (ev_ok && (len_q == FULL_LEN)) begin
                    key_d     = code_q;
                    key_upd_d = 1'b1;
                    state_d   = S_WAIT;
                end else if (back_acc) begin
                    code_d = code_pop;
                    len_d  = len_q - 1'b1;
                    reload = 1'b1;
                end else if (dig_acc) begin
                    code_d = code_push;
                    len_d  = len_q + 1'b1;
                    reload = 1'b1;
                end else if (ev_admin || tmr_exp) begin
                    state_d = S_UNLOCK;
                end
            end

            default: begin
                state_d = S_WAIT;
            end
        endcase

        // Every state entry other than the first digit starts with an empty code.
        if ((state_d != state_q) && (state_d != S_INPUT)) begin
            code_d = '0;
            len_d  = '0;
        end

        // Loaded with HOLD-1 so the state lasts exactly HOLD cycles.
        tmr_load = (state_d != state_q) || reload;
        unique case (state_d)
            S_INPUT,
            S_SETKEY: tmr_value = TMR_W'(IDLE_TO - 1);
            S_ERROR:  tmr_value = TMR_W'(ERR_HOLD - 1);
            S_ALARM:  tmr_value = TMR_W'(ALARM_HOLD - 1);
            S_UNLOCK: tmr_value = TMR_W'(UNLOCK_HOLD - 1);
            default:  tmr_value = '0;
        endcase
    end

    assign tmr_en = (state_q != S_WAIT);

    hold_timer #(
        .WIDTH (TMR_W)
    ) u_hold_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (tmr_load),
        .value_i   (tmr_value),
        .en_i      (tmr_en),
        .expired_o (tmr_exp)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_WAIT;
            code_q    <= '0;
            len_q     <= '0;
            err_q     <= '0;
            key_q     <= DEFAULT_KEY;
            key_upd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            len_q     <= len_d;
            err_q     <= err_d;
            key_q     <= key_d;
            key_upd_q <= key_upd_d;
        end
    end

    assign state_o       = state_q;
    assign code_o        = code_q;
    assign code_len_o    = len_q;
    assign err_cnt_o     = err_q;
    assign unlocked_o    = (state_q == S_UNLOCK);
    assign alarm_on_o    = (state_q == S_ALARM);
    assign admin_mode_o  = (state_q == S_SETKEY);
    assign key_updated_o = key_upd_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_seq_ctrl.sv
`default_nettype none
// =============================================================================
// tb_lock_seq_ctrl : directed self-checking bench for lock_seq_ctrl
// Revision         : 1.0
// =============================================================================
module tb_lock_seq_ctrl;

    localparam int ERR_HOLD    = 20;
    localparam int ALARM_HOLD  = 30;
    localparam int UNLOCK_HOLD = 40;
    localparam int IDLE_TO     = 25;

    localparam logic [2:0] ST_WAIT   = 3'd0;
    localparam logic [2:0] ST_INPUT  = 3'd1;
    localparam logic [2:0] ST_ERROR  = 3'd2;
    localparam logic [2:0] ST_ALARM  = 3'd3;
    localparam logic [2:0] ST_UNLOCK = 3'd4;
    localparam logic [2:0] ST_SETKEY = 3'd5;

    logic        clk;
    logic        rst_n;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        btn_ok;
    logic        btn_back;
    logic        btn_admin;
    logic [2:0]  state;
    logic [15:0] code;
    logic [2:0]  code_len;
    logic [1:0]  err_cnt;
    logic        unlocked;
    logic        alarm_on;
    logic        admin_mode;
    logic        key_updated;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    lock_seq_ctrl #(
        .MAX_ERRORS  (3),
        .DEFAULT_KEY (16'h1234),
        .ERR_HOLD    (ERR_HOLD),
        .ALARM_HOLD  (ALARM_HOLD),
        .UNLOCK_HOLD (UNLOCK_HOLD),
        .IDLE_TO     (IDLE_TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .digit_valid_i (digit_valid),
        .digit_i       (digit),
        .btn_ok_i      (btn_ok),
        .btn_back_i    (btn_back),
        .btn_admin_i   (btn_admin),
        .state_o       (state),
        .code_o        (code),
        .code_len_o    (code_len),
        .err_cnt_o     (err_cnt),
        .unlocked_o    (unlocked),
        .alarm_on_o    (alarm_on),
        .admin_mode_o  (admin_mode),
        .key_updated_o (key_updated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the pulse is sampled at the next rising edge
    // and the response is visible when this returns.
    task automatic ev(input logic ok, input logic back, input logic dv,
                      input logic [3:0] d, input logic adm);
        btn_ok = ok; btn_back = back; digit_valid = dv; digit = d; btn_admin = adm;
        @(negedge clk);
        btn_ok = 1'b0; btn_back = 1'b0; digit_valid = 1'b0; digit = 4'd0; btn_admin = 1'b0;
    endtask

    task automatic dig(input logic [3:0] d);  ev(1'b0, 1'b0, 1'b1, d, 1'b0);    endtask
    task automatic press_ok();                ev(1'b1, 1'b0, 1'b0, 4'd0, 1'b0); endtask
    task automatic press_back();              ev(1'b0, 1'b1, 1'b0, 4'd0, 1'b0); endtask
    task automatic press_admin();             ev(1'b0, 1'b0, 1'b0, 4'd0, 1'b1); endtask

    task automatic enter(input logic [15:0] c);
        dig(c[15:12]); dig(c[11:8]); dig(c[7:4]); dig(c[3:0]);
    endtask

    task automatic wait_leave(input logic [2:0] st, input int budget, output int cnt);
        cnt = 0;
        while ((state == st) && (cnt < budget)) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_state"}, state, ST_WAIT);
        chk({tag, "_code"},  code, 16'h0);
        chk({tag, "_len"},   code_len, 3'd0);
        chk({tag, "_err"},   err_cnt, 2'd0);
        chk({tag, "_flags"}, {unlocked, alarm_on, admin_mode, key_updated}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; digit_valid = 1'b0; digit = 4'd0;
        btn_ok = 1'b0; btn_back = 1'b0; btn_admin = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_state", state, ST_WAIT);
        chk("rst_code",  code, 16'h0);
        chk("rst_len",   code_len, 3'd0);
        chk("rst_err",   err_cnt, 2'd0);
        chk("rst_flags", {unlocked, alarm_on, admin_mode, key_updated}, 4'b0000);

        // Correct default key unlocks; fifth digit is dropped
        dig(4'd1);
        chk("d1_state", state, ST_INPUT);
        chk("d1_code",  code, 16'h0001);
        chk("d1_len",   code_len, 3'd1);
        dig(4'd2); dig(4'd3); dig(4'd4);
        chk("d4_code", code, 16'h1234);
        chk("d4_len",  code_len, 3'd4);
        dig(4'd5);
        chk("d5_code", code, 16'h1234);
        chk("d5_len",  code_len, 3'd4);
        press_ok();
        chk("t1_unlocked", unlocked, 1'b1);
        chk("t1_state",    state, ST_UNLOCK);
        chk("t1_err",      err_cnt, 2'd0);
        chk("t1_code",     code, 16'h0);
        dig(4'd7);
        chk("unl_dig_ign", {state, code_len}, {ST_UNLOCK, 3'd0});
        press_ok();
        chk("relock", {state, unlocked}, {ST_WAIT, 1'b0});
        press_ok(); press_back(); press_admin();
        chk("wait_ign", {state, code_len}, {ST_WAIT, 3'd0});

        // Wrong code -> ERROR for ERR_HOLD cycles
        enter(16'h1235);
        press_ok();
        chk("t2_state", state, ST_ERROR);
        chk("t2_err",   err_cnt, 2'd1);
        chk("t2_code",  code, 16'h0);
        dig(4'd1);
        chk("t2_ign", {state, code_len}, {ST_ERROR, 3'd0});
        wait_leave(ST_ERROR, 200, n);
        chk("t2_hold", n + 1, ERR_HOLD);
        chk("t2_wait", state, ST_WAIT);
        chk("t2_err_kept", err_cnt, 2'd1);

        // Short entry fails, third failure raises ALARM
        dig(4'd1); dig(4'd2);
        press_ok();
        chk("t3_state2", state, ST_ERROR);
        chk("t3_err2",   err_cnt, 2'd2);
        wait_leave(ST_ERROR, 200, n);
        chk("t3_hold2", n, ERR_HOLD);
        enter(16'h0000);
        press_ok();
        chk("t3_alarm", {state, alarm_on}, {ST_ALARM, 1'b1});
        press_admin();
        chk("t3_adm_ign", {state, admin_mode}, {ST_ALARM, 1'b0});
        wait_leave(ST_ALARM, 200, n);
        chk("t3_hold", n + 1, ALARM_HOLD);
        chk("t3_wait", {state, alarm_on}, {ST_WAIT, 1'b0});
        chk("t3_err0", err_cnt, 2'd0);

        // Key change through SETKEY
        enter(16'h1234);
        press_ok();
        chk("t4_unl", unlocked, 1'b1);
        press_admin();
        chk("t4_setkey", {state, admin_mode}, {ST_SETKEY, 1'b1});
        press_back();
        chk("t4_back0", {state, code_len}, {ST_SETKEY, 3'd0});
        dig(4'd9); dig(4'd8); dig(4'd7);
        press_ok();
        chk("t4_short_ok", {state, code_len, key_updated}, {ST_SETKEY, 3'd3, 1'b0});
        dig(4'd6);
        chk("t4_code", code, 16'h9876);
        press_ok();
        chk("t4_kupd",  key_updated, 1'b1);
        chk("t4_wait",  {state, code}, {ST_WAIT, 16'h0});
        @(negedge clk);
        chk("t4_kupd_pulse", key_updated, 1'b0);
        enter(16'h9876);
        press_ok();
        chk("t4_new_key", state, ST_UNLOCK);
        press_admin();
        dig(4'd1);
        press_admin();
        chk("t4_adm_back", {state, code_len, key_updated}, {ST_UNLOCK, 3'd0, 1'b0});
        press_ok();
        enter(16'h1234);
        press_ok();
        chk("t4_old_fail", {state, err_cnt}, {ST_ERROR, 2'd1});
        wait_leave(ST_ERROR, 200, n);

        // Auto-relock and idle abandon
        enter(16'h9876);
        press_ok();
        chk("unl_err0", {state, err_cnt}, {ST_UNLOCK, 2'd0});
        wait_leave(ST_UNLOCK, 200, n);
        chk("unl_hold", n, UNLOCK_HOLD);
        chk("unl_wait", state, ST_WAIT);
        dig(4'd1); dig(4'd2);
        wait_leave(ST_INPUT, 200, n);
        chk("idle_to",   n, IDLE_TO);
        chk("idle_wait", {state, code, code_len}, {ST_WAIT, 16'h0, 3'd0});

        // Backspace and same-cycle priority
        dig(4'd1); dig(4'd2);
        press_back();
        chk("t5_back1", {state, code, code_len}, {ST_INPUT, 16'h0001, 3'd1});
        press_back();
        chk("t5_back2", {state, code, code_len}, {ST_WAIT, 16'h0, 3'd0});
        dig(4'd3); dig(4'd4);
        ev(1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
        chk("t5_back_wins", {code, code_len}, {16'h0003, 3'd1});
        dig(4'hA);
        chk("t5_nonbcd", {code, code_len}, {16'h0003, 3'd1});
        ev(1'b0, 1'b0, 1'b1, 4'd4, 1'b1);
        chk("t5_dig_wins", {state, code, code_len}, {ST_INPUT, 16'h0034, 3'd2});
        press_back(); press_back();
        chk("t5_wait", state, ST_WAIT);

        // Reset during ALARM and during SETKEY
        enter(16'h1111); press_ok(); wait_leave(ST_ERROR, 200, n);
        enter(16'h2222); press_ok(); wait_leave(ST_ERROR, 200, n);
        enter(16'h3333); press_ok();
        chk("t6_alarm", state, ST_ALARM);
        async_reset("t6_rstA");
        enter(16'h1234);
        press_ok();
        chk("t6_key_def", state, ST_UNLOCK);
        press_admin();
        dig(4'd5); dig(4'd5);
        chk("t6_setkey", {state, code_len}, {ST_SETKEY, 3'd2});
        async_reset("t6_rstS");
        enter(16'h9876);
        press_ok();
        chk("t6_key_9876_fails", {state, err_cnt}, {ST_ERROR, 2'd1});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
